// File: rtl/score_pkg.sv
// Shared definitions for the obstacle scoring path: pulse FSM encoding,
// default player threshold and the gap-length rule.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } pulse_state_t;

  localparam int DEFAULT_PLAYER_Y = 400;
  localparam int GAP_MIN          = 1;
  localparam int GAP_CNT_W        = 4;

  // Gap counter load value; a gap shorter than one cycle would let two
  // highs touch, so anything below GAP_MIN is treated as GAP_MIN.
  function automatic logic [GAP_CNT_W-1:0] gap_load(input int gap_cycles);
    return (gap_cycles < GAP_MIN) ? '0 : GAP_CNT_W'(gap_cycles - 1);
  endfunction

endpackage

// File: rtl/crossing_popcount.sv
// Combinational popcount of the per-slot credited-crossing flags.
module crossing_popcount #(
  parameter int NUM_OBST = 4,
  parameter int CW       = $clog2(NUM_OBST + 1)
) (
  input  logic [NUM_OBST-1:0] bits,
  output logic [CW-1:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_OBST; i++)
      count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/obstacle_pass_scorer.sv
// Converts obstacles passing the player into serialised score pulses,
// each followed by a forced low gap so the downstream edge detector sees every credit.
module obstacle_pass_scorer
  import score_pkg::*;
#(
  parameter int NUM_OBST   = 4,
  parameter int Y_W        = 9,
  parameter int PLAYER_Y   = DEFAULT_PLAYER_Y,
  parameter int PEND_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    game_running,
  input  logic [NUM_OBST-1:0]     obst_active,
  input  logic [NUM_OBST*Y_W-1:0] obst_y,
  input  logic [NUM_OBST-1:0]     obst_hit,
  output logic                    score_increment,
  output logic [PEND_W-1:0]       pending,
  output logic                    overflow
);

  localparam int CW = $clog2(NUM_OBST + 1);
  localparam int SW = PEND_W + CW + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NUM_OBST-1:0]  armed;
  logic [NUM_OBST-1:0]  past;
  logic [NUM_OBST-1:0]  credit;
  logic [CW-1:0]        new_cnt;
  logic                 dec;
  logic [SW-1:0]        sum;
  pulse_state_t         state;
  logic [GAP_CNT_W-1:0] gap_cnt;

  for (genvar g = 0; g < NUM_OBST; g++) begin : g_slot
    assign past[g] = obst_y[g*Y_W +: Y_W] >= Y_W'(PLAYER_Y);
  end

  assign credit = {NUM_OBST{game_running}} & armed & obst_active & past & ~obst_hit;

  crossing_popcount #(.NUM_OBST(NUM_OBST), .CW(CW)) u_popcount (
    .bits  (credit),
    .count (new_cnt)
  );

  assign dec = (state == ST_IDLE) && (pending != '0);
  assign sum = SW'(pending) + SW'(new_cnt) - SW'(dec);

  // While running, a slot at/past the threshold is disarmed whether or not it
  // just crossed, so a slot is armed exactly when it is active and still above.
  always_ff @(posedge Clock) begin
    if (!Resetn)
      armed <= '0;
    else if (game_running)
      armed <= obst_active & ~past;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (sum > SW'(PEND_MAX)) begin
      pending  <= PEND_MAX;
      overflow <= 1'b1;
    end else begin
      pending  <= sum[PEND_W-1:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state           <= ST_IDLE;
      gap_cnt         <= '0;
      score_increment <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (pending != '0) begin
          state           <= ST_HIGH;
          score_increment <= 1'b1;
        end
        ST_HIGH: begin
          state           <= ST_GAP;
          score_increment <= 1'b0;
          gap_cnt         <= gap_load(GAP_CYCLES);
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          state           <= ST_IDLE;
          score_increment <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_pass_scorer.sv
// Bench for obstacle_pass_scorer: directed scenarios plus random traffic against
// a credit/pulse-spacing reference model.
module tb_obstacle_pass_scorer;

  localparam int N    = 4;
  localparam int YW   = 9;
  localparam int PY   = 400;
  localparam int PW   = 4;
  localparam int GAP  = 1;
  localparam int PMAX = (1 << PW) - 1;

  logic            Clock = 1'b0;
  logic            Resetn = 1'b0;
  logic            game_running = 1'b0;
  logic [N-1:0]    obst_active = '0;
  logic [N*YW-1:0] obst_y = '0;
  logic [N-1:0]    obst_hit = '0;
  logic            score_increment;
  logic [PW-1:0]   pending;
  logic            overflow;

  int nvec = 0;
  int nerr = 0;

  obstacle_pass_scorer #(
    .NUM_OBST(N), .Y_W(YW), .PLAYER_Y(PY), .PEND_W(PW), .GAP_CYCLES(GAP)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .game_running(game_running),
    .obst_active(obst_active), .obst_y(obst_y), .obst_hit(obst_hit),
    .score_increment(score_increment), .pending(pending), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  // Reference: credits counted from the passing rule, pulses spaced by time
  // since the last pulse, armed = "seen active and above the line".
  int        m_pend = 0;
  bit        m_ovf = 0, m_si = 0;
  bit [N-1:0] m_armed = '0;
  int        ecyc = 0, m_last = -1000;
  int        m_cr;
  bit        m_fire;

  always @(posedge Clock) begin
    ecyc++;
    if (!Resetn) begin
      m_pend = 0; m_ovf = 0; m_si = 0; m_armed = '0; m_last = -1000;
    end else begin
      m_cr = 0;
      for (int i = 0; i < N; i++)
        if (game_running && m_armed[i] && obst_active[i] &&
            int'(obst_y[i*YW +: YW]) >= PY && !obst_hit[i]) m_cr++;
      m_fire = (m_pend > 0) && (ecyc - m_last >= GAP + 2);
      m_pend = m_pend + m_cr - (m_fire ? 1 : 0);
      if (m_pend > PMAX) begin m_pend = PMAX; m_ovf = 1; end
      m_si = m_fire;
      if (m_fire) m_last = ecyc;
      if (game_running)
        for (int i = 0; i < N; i++)
          m_armed[i] = obst_active[i] && int'(obst_y[i*YW +: YW]) < PY;
    end
  end

  // Stand-in for score_counter: counts rising edges.
  int pulse_cnt = 0;
  bit si_prev = 0;
  always @(negedge Clock) begin
    if (score_increment && !si_prev) pulse_cnt++;
    si_prev = score_increment;
  end

  task automatic set_y(input int i, input int v);
    obst_y[i*YW +: YW] = YW'(v);
  endtask

  task automatic set_all_y(input int v);
    for (int i = 0; i < N; i++) set_y(i, v);
  endtask

  // Pending count after the next two edges if k credits land on the first.
  function automatic int pred2(input int k);
    int p, last, e;
    bit f;
    e = ecyc + 1;
    f = (m_pend > 0) && (e - m_last >= GAP + 2);
    p = m_pend + k - (f ? 1 : 0);
    if (p > PMAX) p = PMAX;
    last = f ? e : m_last;
    e++;
    f = (p > 0) && (e - last >= GAP + 2);
    return p - (f ? 1 : 0);
  endfunction

  task automatic test_reset();
    Resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== '0) begin
        nerr++;
        $display("FAIL reset c%0d: si/pend/ovf got %b/%0d/%b want 0/0/0", c, score_increment, pending, overflow);
      end
    end
    Resetn = 1'b1;
    game_running = 1'b1;
    #1;
  endtask

  task automatic test_single_pass();
    int p0;
    p0 = pulse_cnt;
    obst_active[0] = 1'b1; set_y(0, 398);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL single_pass c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
      if (c == 0) set_y(0, 399);
      else if (c == 1) set_y(0, 400);
      else if (c == 5) obst_active[0] = 1'b0;
    end
    #1; nvec++;
    if (pulse_cnt - p0 !== 1) begin
      nerr++; $display("FAIL single_pass_count: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_hit_suppression();
    int p0;
    p0 = pulse_cnt;
    obst_active[1] = 1'b1; set_y(1, 390);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL hit_suppress c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
      if (c == 0) begin set_y(1, 400); obst_hit[1] = 1'b1; end
      else if (c == 1) begin set_y(1, 401); obst_hit[1] = 1'b0; end
      else if (c == 4) set_y(1, 450);
    end
    obst_active[1] = 1'b0;
    #1; nvec++;
    if (pulse_cnt - p0 !== 0) begin
      nerr++; $display("FAIL hit_suppress_count: got %0d want 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_simultaneous();
    int p0;
    bit prev;
    p0 = pulse_cnt; prev = 0;
    obst_active = '1; set_all_y(399);
    @(negedge Clock);
    set_all_y(400);
    @(negedge Clock);
    nvec++;
    if (pending !== PW'(4)) begin
      nerr++; $display("FAIL simul_pending: got %0d want 4", pending);
    end
    obst_active = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL simul c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
      nvec++;
      if (score_increment && prev) begin
        nerr++; $display("FAIL simul_back_to_back c%0d: got high twice want gap", c);
      end
      prev = score_increment;
    end
    #1; nvec++;
    if (pulse_cnt - p0 !== 4) begin
      nerr++; $display("FAIL simul_count: got %0d want 4", pulse_cnt - p0);
    end
  endtask

  task automatic test_game_over_respawn();
    int p0;
    p0 = pulse_cnt;
    obst_active = 4'b0111; set_all_y(300);
    @(negedge Clock);
    set_y(0, 400); set_y(1, 400);
    for (int c = 0; c < 16; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL game_over c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
      if (c == 0) begin game_running = 1'b0; set_y(2, 400); end
      else if (c == 10) obst_active[2] = 1'b0;
      else if (c == 12) game_running = 1'b1;
    end
    #1; nvec++;
    if (pulse_cnt - p0 !== 2) begin
      nerr++; $display("FAIL game_over_count: got %0d want 2", pulse_cnt - p0);
    end
    p0 = pulse_cnt;
    obst_active = 4'b0100; set_y(2, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL respawn c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
      if (c == 0) set_y(2, 400);
    end
    obst_active = '0;
    #1; nvec++;
    if (pulse_cnt - p0 !== 1) begin
      nerr++; $display("FAIL respawn_count: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_saturation();
    int p0, best;
    obst_active = '1; set_all_y(0); obst_hit = '0;
    @(negedge Clock);
    for (int it = 0; it < 30 && m_pend != 14; it++) begin
      best = 0;
      for (int k = 0; k <= N; k++) if (pred2(k) <= 14) best = k;
      for (int i = 0; i < N; i++) obst_hit[i] = (i >= best);
      set_all_y(400);
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL sat_fill it%0d: got %b/%0d/%b want %b/%0d/%b", it, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
      obst_hit = '0; set_all_y(0);
      @(negedge Clock);
    end
    nvec++;
    if (pending !== PW'(14) || overflow !== 1'b0) begin
      nerr++; $display("FAIL sat_pre: pend/ovf got %0d/%b want 14/0", pending, overflow);
    end
    set_all_y(400);
    @(negedge Clock);
    nvec++;
    if (pending !== PW'(PMAX) || overflow !== 1'b1) begin
      nerr++; $display("FAIL sat_hit: pend/ovf got %0d/%b want 15/1", pending, overflow);
    end
    obst_active = '0;
    #1; p0 = pulse_cnt;
    for (int c = 0; c < 52; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL sat_drain c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
    end
    #1; nvec++;
    if (pulse_cnt - p0 !== 15 || overflow !== 1'b1) begin
      nerr++; $display("FAIL sat_count: pulses/ovf got %0d/%b want 15/1", pulse_cnt - p0, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    obst_active = '1; set_all_y(0);
    @(negedge Clock);
    set_all_y(400);
    @(negedge Clock);
    obst_active = '0;
    @(negedge Clock);
    nvec++;
    if (score_increment !== 1'b1 || pending !== PW'(3)) begin
      nerr++; $display("FAIL rst_mid_pre: si/pend got %b/%0d want 1/3", score_increment, pending);
    end
    Resetn = 1'b0;
    @(negedge Clock);
    nvec++;
    if ({score_increment, pending, overflow} !== '0) begin
      nerr++; $display("FAIL rst_mid: si/pend/ovf got %b/%0d/%b want 0/0/0", score_increment, pending, overflow);
    end
    Resetn = 1'b1;
    #1; p0 = pulse_cnt;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL rst_mid_after c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
    end
    #1; nvec++;
    if (pulse_cnt - p0 !== 0) begin
      nerr++; $display("FAIL rst_mid_count: got %0d want 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      game_running = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        obst_active[i] = ($urandom_range(0, 7) != 0);
        obst_hit[i]    = ($urandom_range(0, 5) == 0);
        set_y(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(396, 404)));
      end
      @(negedge Clock);
      nvec++;
      if ({score_increment, pending, overflow} !== {m_si, PW'(m_pend), m_ovf}) begin
        nerr++;
        $display("FAIL random c%0d: got %b/%0d/%b want %b/%0d/%b", c, score_increment, pending, overflow, m_si, m_pend, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_hit_suppression();
    test_simultaneous();
    test_game_over_respawn();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obstacle_pass_scorer.md
# obstacle_pass_scorer

- Producer side of the score-increment interface: watches the obstacle y-coordinates and emits one clean `score_increment` pulse per obstacle that passes the player without a collision.
- Sits between the obstacle engine and `score_counter`.
- `score_counter` edge-detects its input, so every credit needs a distinct rising edge. This block therefore queues simultaneous passes and serialises them as pulses separated by enforced low gaps.

## Interface
Parameters:
- `NUM_OBST`, 4, number of obstacle slots
- `Y_W`, 9, obstacle y-coordinate width
- `PLAYER_Y`, 400, y threshold; an obstacle passes when its y reaches this value
- `PEND_W`, 4, pending-credit counter width
- `GAP_CYCLES`, 1, low cycles after each pulse (legal range 1..15)

Ports:
- `Clock`  in  1  system clock
- `Resetn`  in  1  reset, synchronous, active-low
- `game_running`  in  1  high while play is active
- `obst_active`  in  NUM_OBST  per-slot obstacle valid
- `obst_y`  in  NUM_OBST*Y_W  packed y, slot i at [i*Y_W +: Y_W]
- `obst_hit`  in  NUM_OBST  per-slot collision with player, level
- `score_increment`  out  1  credit pulse to `score_counter`
- `pending`  out  PEND_W  credits queued, not yet pulsed
- `overflow`  out  1  sticky; a credit was lost at saturation

## Operation
- Each slot has an `armed` bit.
  - Set when `obst_active & (y < PLAYER_Y)`.
  - Cleared when `!obst_active`.
- Crossing for slot i, evaluated only when `game_running`: `armed & obst_active & (y >= PLAYER_Y)`.
  - A crossing always clears `armed`, so each spawn counts once.
  - It yields a credit only if `!obst_hit[i]` in the same cycle.
- Per-cycle credit count `new` = popcount of credited crossings, range 0..NUM_OBST.
- `game_running` low: no crossings are evaluated and `armed` bits hold. Queued credits still drain.
- Pending update: `pending_next = pending + new - dec`.
  - `dec` is 1 on the IDLE->HIGH transition, else 0.
  - The result saturates at `2^PEND_W-1`.
  - Any truncated credit sets `overflow`; only reset clears it.
- Pulse FSM:
  - IDLE: `score_increment = 0`. Go to HIGH when `pending != 0`.
  - HIGH: `score_increment = 1` for exactly one cycle, then go to GAP and load the gap counter with `GAP_CYCLES-1`.
  - GAP: `score_increment = 0`. Count down; at 0 go to IDLE.
- Reset values:
  - `score_increment` = 0, `pending` = 0, `overflow` = 0
  - FSM = IDLE, all `armed` = 0, gap counter = 0
- Reset mid-pulse drops `score_increment` low at the next edge and discards queued credits.

## Timing
- All outputs are registered.
- A crossing sampled at edge k appears in `pending` after edge k.
- `score_increment` goes high after edge k+1 and low after edge k+2.
- Pulse period is `2 + GAP_CYCLES` cycles: HIGH, GAP_CYCLES×GAP, IDLE. With the default of 1, that is one credit per 3 cycles.
- `score_increment` is never high on two consecutive cycles, so `score_counter` sees exactly one rising edge per credit.
- Simultaneous crossing and IDLE->HIGH transition: both are applied in the same update, per the `pending_next` formula.
- An obstacle that spawns already at `y >= PLAYER_Y` is never armed and never scores.

## Structure
- Shared package `score_pkg` holds:
  - the FSM state encoding (IDLE, HIGH, GAP)
  - default `PLAYER_Y`
  - the rule `GAP_CYCLES >= 1`
- Sub-module `crossing_popcount`: combinational NUM_OBST-bit popcount of credited crossings. Output width is clog2(NUM_OBST+1).
- The top level holds the `armed` bits, the pending counter with saturation and overflow, and the FSM.

## Test plan
- Single pass: slot 0 active, y stepping 398→399→400, no hit → `pending` 1 then 0; one `score_increment` pulse, 1 cycle wide; `score_counter` shows 001.
- Hit suppression: slot 1 reaches 400 with `obst_hit[1]=1` → no pulse. Holding y at 401+ with hit released → still no pulse, since the slot is disarmed.
- Simultaneous passes: all 4 slots cross on the same edge → `pending` = 4, then four pulses 3 cycles apart. No back-to-back highs; counter ends at 004.
- Saturation: `pending` = 14, then 4 credits on one edge → `pending` = 15 and `overflow` = 1. Exactly 15 pulses follow; `overflow` stays 1.
- Game over / respawn: `game_running=0` while slot 2 crosses → no credit, and queued credits still drain. Then drop `obst_active[2]` and respawn at y=0 → a later crossing scores normally.
- Reset mid-operation: `Resetn=0` during HIGH with `pending` = 3 → after the edge `score_increment` = 0, `pending` = 0, `overflow` = 0, and no further pulses.
